// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver. Oversamples the asynchronous rx line, finds the start
// bit, recovers DATA_BITS data bits LSB-first, checks the stop bit and hands
// the byte to the receive FIFO over a valid/ready interface. Framing and
// overrun conditions are kept as sticky flags for the CSR layer.
//
// Ports:
//   clk_i      system clock
//   reset_i    asynchronous, active-low reset
//   prescaler  baud tick divider; one tick every prescaler+1 clocks
//   rx         serial line, idle high, asynchronous to clk_i
//   d_out      received byte, stable while valid is high
//   valid      byte available
//   ready      consumer accepts; transfer on valid && ready
//   frame_err  sticky: stop bit sampled low
//   overrun    sticky: byte completed while the previous one was unread
//   err_clr    clears frame_err and overrun on the next edge
//   busy       high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [31:0]          prescaler,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] d_out,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 overrun,
    input  logic                 err_clr,
    output logic                 busy
);

    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [OS_W-1:0]  HALF_LAST = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  FULL_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t               state;
    state_t               state_next;

    logic                 rx_meta;
    logic                 rs;
    logic                 rs_last;
    logic                 start_edge;

    logic [31:0]          presc_q;
    logic [31:0]          tick_cnt;
    logic                 tick;

    logic [OS_W-1:0]      os_cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shreg;

    logic                 frame_start;
    logic                 os_wrap;
    logic                 sample_data;
    logic                 good_stop;
    logic                 bad_stop;
    logic                 load_byte;
    logic                 drop_byte;

    assign start_edge = rs_last & ~rs;
    assign tick       = (tick_cnt == presc_q);
    assign busy       = (state != S_IDLE);

    // Two-flop synchronizer plus a one-cycle history of the synchronized
    // line. Everything resets to the idle-high level so a line that is
    // already low coming out of reset is seen as a start edge.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            rx_meta <= 1'b1;
            rs      <= 1'b1;
            rs_last <= 1'b1;
        end else begin
            rx_meta <= rx;
            rs      <= rx_meta;
            rs_last <= rs;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the per-cycle strobes that drive the datapath.
    // os_wrap marks the tick on which a sample is taken, which also restarts
    // the oversample count for the next bit period.
    always_comb begin
        state_next  = state;
        frame_start = 1'b0;
        os_wrap     = 1'b0;
        sample_data = 1'b0;
        good_stop   = 1'b0;
        bad_stop    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_edge) begin
                    frame_start = 1'b1;
                    state_next  = S_START;
                end
            end
            S_START: begin
                if (tick && (os_cnt == HALF_LAST)) begin
                    os_wrap    = 1'b1;
                    state_next = rs ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (tick && (os_cnt == FULL_LAST)) begin
                    os_wrap     = 1'b1;
                    sample_data = 1'b1;
                    if (bit_idx == IDX_LAST) begin
                        state_next = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (tick && (os_cnt == FULL_LAST)) begin
                    os_wrap = 1'b1;
                    if (rs) begin
                        good_stop  = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        bad_stop   = 1'b1;
                        state_next = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (rs) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // A completed byte is accepted only if the output slot is empty or is
    // being emptied in this very cycle; otherwise it is dropped as overrun.
    assign load_byte = good_stop & (~valid | ready);
    assign drop_byte = good_stop & valid & ~ready;

    // Baud tick generator. The divider is captured at the start edge so a
    // prescaler change mid-frame cannot disturb the bit timing, and the
    // counter sits at zero while idle so the sampling phase is referenced
    // to the detected edge.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            presc_q  <= '0;
            tick_cnt <= '0;
        end else begin
            if (frame_start) begin
                presc_q <= prescaler;
            end
            if (state == S_IDLE) begin
                tick_cnt <= '0;
            end else if (tick) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + 32'd1;
            end
        end
    end

    // Oversample counter, bit index and shift register. Data bits land
    // directly in their final position, LSB first.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            os_cnt  <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if (state == S_IDLE) begin
                os_cnt <= '0;
            end else if (tick) begin
                os_cnt <= os_wrap ? '0 : os_cnt + 1'b1;
            end
            if (frame_start) begin
                bit_idx <= '0;
            end else if (sample_data) begin
                bit_idx <= bit_idx + 1'b1;
            end
            if (sample_data) begin
                shreg[bit_idx] <= rs;
            end
        end
    end

    // Output register and handshake. A byte loading in the same cycle as a
    // transfer keeps valid high.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            d_out <= '0;
            valid <= 1'b0;
        end else begin
            if (load_byte) begin
                d_out <= shreg;
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

    // Sticky error flags. A new error event in the same cycle as err_clr
    // leaves the flag set.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= bad_stop  | (frame_err & ~err_clr);
            overrun   <= drop_byte | (overrun   & ~err_clr);
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Self-checking bench for uart_rx. Frames are generated at the bit level
// from the byte value and the bit period; a small behavioural model of a
// one-entry receive buffer decides which bytes must reach the consumer and
// which flags must be raised. Expected bytes go into a queue that a
// separate monitor drains whenever the DUT transfers a byte.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [31:0] prescaler;
    logic        rx;
    logic [7:0]  d_out;
    logic        valid;
    logic        ready;
    logic        frame_err;
    logic        overrun;
    logic        err_clr;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rx_fall_cyc = 0;
    int          valid_rise_cyc = -1;
    int          valid_len = 0;
    int          last_pulse_len = 0;
    logic        valid_prev = 1'b0;
    logic [7:0]  exp_q[$];
    logic        exp_frame_err = 1'b0;
    logic        exp_overrun = 1'b0;

    uart_rx #(
        .OVERSAMPLE(OVERSAMPLE),
        .DATA_BITS (DATA_BITS)
    ) dut (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .prescaler(prescaler),
        .rx       (rx),
        .d_out    (d_out),
        .valid    (valid),
        .ready    (ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .err_clr  (err_clr),
        .busy     (busy)
    );

    // Free-running clock and a cycle counter used for latency measurement.
    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        cyc++;
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic check_range(input string name, input int actual, input int lo, input int hi);
        checks++;
        if (actual < lo || actual > hi) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d..%0d", name, actual, lo, hi);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    // Drives one frame: start bit, data LSB first, then either a normal stop
    // bit or a stop bit held low for stop_low_bits bit times. In the latter
    // case the line is left low for the caller to release.
    task automatic apply_stimulus(input logic [7:0] data, input int bit_clk,
                                  input int stop_low_bits);
        rx = 1'b0;
        rx_fall_cyc = cyc;
        idle(bit_clk);
        for (int i = 0; i < DATA_BITS; i++) begin
            rx = data[i];
            idle(bit_clk);
        end
        if (stop_low_bits > 0) begin
            rx = 1'b0;
            idle(stop_low_bits * bit_clk);
        end else begin
            rx = 1'b1;
            idle(bit_clk);
        end
    endtask

    // Reference model of the receive buffer: a good frame is delivered unless
    // an earlier byte is still waiting for a stalled consumer.
    task automatic send_good(input logic [7:0] data, input int bit_clk);
        if (!ready && exp_q.size() > 0) begin
            exp_overrun = 1'b1;
        end else begin
            exp_q.push_back(data);
        end
        apply_stimulus(data, bit_clk, 0);
    endtask

    task automatic send_bad(input logic [7:0] data, input int bit_clk);
        exp_frame_err = 1'b1;
        apply_stimulus(data, bit_clk, 2);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            idle(1);
            n++;
        end
        check_output("queue_drained", exp_q.size(), 0);
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        exp_frame_err = 1'b0;
        exp_overrun   = 1'b0;
        check_output("frame_err_cleared", frame_err, 1'b0);
        check_output("overrun_cleared", overrun, 1'b0);
    endtask

    // Monitor: every transfer pops the oldest expected byte and compares.
    // It also tracks when valid rises and how long each pulse lasts.
    always @(negedge clk_i) begin
        if (reset_i) begin
            if (valid && !valid_prev) begin
                valid_rise_cyc = cyc;
            end
            if (valid) begin
                valid_len++;
            end else if (valid_len > 0) begin
                last_pulse_len = valid_len;
                valid_len = 0;
            end
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_valid actual=%0h expected=none", d_out);
                end else begin
                    check_output("d_out", d_out, exp_q.pop_front());
                end
            end
        end
        valid_prev = valid;
    end

    // Watchdog so a stuck DUT cannot hang the run.
    initial begin
        #600000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence.
    initial begin
        logic [7:0] data;
        int         p;
        reset_i   = 1'b0;
        prescaler = 32'd0;
        rx        = 1'b1;
        ready     = 1'b1;
        err_clr   = 1'b0;
        idle(3);
        check_output("reset_d_out", d_out, 8'h00);
        check_output("reset_valid", valid, 1'b0);
        check_output("reset_frame_err", frame_err, 1'b0);
        check_output("reset_overrun", overrun, 1'b0);
        check_output("reset_busy", busy, 1'b0);
        reset_i = 1'b1;
        idle(5);

        $display("[TB] good frame and latency");
        valid_rise_cyc = -1;
        send_good(8'hA5, 16);
        idle(4);
        check_range("valid_latency", valid_rise_cyc - rx_fall_cyc, 153, 155);
        check_output("valid_pulse_len", last_pulse_len, 1);
        check_output("good_frame_err", frame_err, 1'b0);
        check_output("good_overrun", overrun, 1'b0);
        wait_drain(50);

        $display("[TB] back-to-back with stall");
        ready = 1'b0;
        send_good(8'h3C, 16);
        idle(3);
        send_good(8'hC3, 16);
        idle(3);
        check_output("stall_d_out", d_out, 8'h3C);
        check_output("stall_valid", valid, 1'b1);
        check_output("stall_overrun", overrun, exp_overrun);
        ready = 1'b1;
        wait_drain(20);
        idle(2);
        check_output("stall_valid_after", valid, 1'b0);
        pulse_err_clr();

        $display("[TB] framing error");
        send_bad(8'h55, 16);
        check_output("ferr_set", frame_err, exp_frame_err);
        check_output("ferr_busy", busy, 1'b1);
        rx = 1'b1;
        idle(5);
        check_output("ferr_busy_released", busy, 1'b0);
        idle(10);
        send_good(8'h12, 16);
        idle(4);
        wait_drain(50);
        check_output("ferr_sticky", frame_err, exp_frame_err);
        pulse_err_clr();

        $display("[TB] glitch rejection");
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(40);
        check_output("glitch_busy", busy, 1'b0);
        check_output("glitch_valid", valid, 1'b0);
        check_output("glitch_frame_err", frame_err, 1'b0);
        send_good(8'hFF, 16);
        idle(4);
        wait_drain(50);

        $display("[TB] prescaler change mid-frame");
        prescaler = 32'd3;
        fork
            send_good(8'h81, 64);
            begin
                idle(64 * 3 + 32);
                prescaler = 32'd0;
            end
        join
        idle(4);
        wait_drain(50);
        send_good(8'h3E, 16);
        idle(4);
        wait_drain(50);
        check_output("presc_flags", {frame_err, overrun}, 2'b00);

        $display("[TB] randomized frames");
        for (int n = 0; n < 16; n++) begin
            p = $urandom_range(0, 2);
            data = 8'($urandom);
            prescaler = 32'(p);
            if ($urandom_range(0, 5) == 0) begin
                send_bad(data, (p + 1) * OVERSAMPLE);
                rx = 1'b1;
            end else begin
                send_good(data, (p + 1) * OVERSAMPLE);
            end
            idle($urandom_range(8, 20));
            wait_drain(200);
            check_output("rand_frame_err", frame_err, exp_frame_err);
            check_output("rand_overrun", overrun, exp_overrun);
            if (exp_frame_err) begin
                pulse_err_clr();
            end
        end

        $display("[TB] reset mid-frame");
        prescaler = 32'd0;
        data = 8'h5A;
        rx = 1'b0;
        idle(16);
        for (int i = 0; i < 4; i++) begin
            rx = data[i];
            idle(16);
        end
        rx = data[4];
        idle(8);
        reset_i = 1'b0;
        #1;
        check_output("midreset_d_out", d_out, 8'h00);
        check_output("midreset_valid", valid, 1'b0);
        check_output("midreset_busy", busy, 1'b0);
        check_output("midreset_flags", {frame_err, overrun}, 2'b00);
        rx = 1'b1;
        idle(3);
        reset_i = 1'b1;
        idle(20);
        check_output("post_reset_idle_valid", valid, 1'b0);
        send_good(8'h77, 16);
        idle(4);
        wait_drain(50);
        check_output("post_reset_d_out", d_out, 8'h77);
        check_output("post_reset_flags", {frame_err, overrun}, 2'b00);

        idle(5);
        check_output("final_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
